// File: rtl/bram_arbiter_if.sv
// rtl/bram_arbiter_if.sv - requester request/ack/read-return bundle for bram_arbiter
interface bram_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;
  logic              ack;
  logic              rvalid;
  logic [15:0]       rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rvalid, rdata
  );
endinterface

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - two-port round-robin arbiter and zero-fill initialiser for bram
module bram_arbiter #(
  parameter  int NUM_BLOCKS = 16,
  localparam int ADDR_W     = 8 + $clog2(NUM_BLOCKS),
  localparam int DEPTH      = NUM_BLOCKS * 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic              init_done,
  bram_arbiter_if.slave     a_if,
  bram_arbiter_if.slave     b_if,
  output logic              bram_rd_en,
  output logic              bram_wr_en,
  output logic [ADDR_W-1:0] bram_rd_addr,
  output logic [ADDR_W-1:0] bram_wr_addr,
  output logic [15:0]       bram_data_in,
  input  logic [15:0]       bram_data_out
);
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic              GNT_A = 1'b0;
  localparam logic              GNT_B = 1'b1;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              init_done_q;
  logic              last_grant_q;
  logic              bram_rd_en_q, bram_wr_en_q;
  logic [ADDR_W-1:0] bram_rd_addr_q, bram_wr_addr_q;
  logic [15:0]       bram_data_in_q;
  logic [1:0]        pipe_v_q;
  logic [1:0]        pipe_id_q;

  logic              grant_a, grant_b, run_ok, ack_a, ack_b;
  logic              sel_we, rd_push, wr_push;
  logic [ADDR_W-1:0] sel_addr;
  logic [15:0]       sel_wdata;

  // On a tie the requester that did not win last time gets the slot.
  always_comb begin
    grant_a   = a_if.req & (!b_if.req | (last_grant_q == GNT_B));
    grant_b   = b_if.req & !grant_a;
    run_ok    = (state_q == ST_RUN) & !clear;
    ack_a     = grant_a & run_ok;
    ack_b     = grant_b & run_ok;
    sel_we    = grant_b ? b_if.we    : a_if.we;
    sel_addr  = grant_b ? b_if.addr  : a_if.addr;
    sel_wdata = grant_b ? b_if.wdata : a_if.wdata;
    rd_push   = (ack_a | ack_b) & !sel_we;
    wr_push   = (ack_a | ack_b) & sel_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_INIT;
      cnt_q          <= '0;
      init_done_q    <= 1'b0;
      last_grant_q   <= GNT_B;
      bram_rd_en_q   <= 1'b0;
      bram_wr_en_q   <= 1'b0;
      bram_rd_addr_q <= '0;
      bram_wr_addr_q <= '0;
      bram_data_in_q <= '0;
      pipe_v_q       <= '0;
      pipe_id_q      <= '0;
    end else begin
      // The response pipe runs in every state so in-flight reads survive a clear.
      pipe_v_q  <= {pipe_v_q[0], rd_push};
      pipe_id_q <= {pipe_id_q[0], grant_b};
      if (ack_a | ack_b) last_grant_q <= grant_b;
      if (state_q == ST_INIT) begin
        bram_wr_en_q   <= 1'b1;
        bram_rd_en_q   <= 1'b0;
        bram_wr_addr_q <= cnt_q;
        bram_data_in_q <= '0;
        cnt_q          <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_q     <= ST_RUN;
          init_done_q <= 1'b1;
        end
      end else begin
        bram_wr_en_q <= wr_push;
        bram_rd_en_q <= rd_push;
        if (wr_push) begin
          bram_wr_addr_q <= sel_addr;
          bram_data_in_q <= sel_wdata;
        end
        if (rd_push) bram_rd_addr_q <= sel_addr;
        if (clear) begin
          state_q     <= ST_INIT;
          cnt_q       <= '0;
          init_done_q <= 1'b0;
        end
      end
    end
  end

  assign init_done    = init_done_q;
  assign bram_rd_en   = bram_rd_en_q;
  assign bram_wr_en   = bram_wr_en_q;
  assign bram_rd_addr = bram_rd_addr_q;
  assign bram_wr_addr = bram_wr_addr_q;
  assign bram_data_in = bram_data_in_q;

  assign a_if.ack    = ack_a;
  assign b_if.ack    = ack_b;
  assign a_if.rvalid = pipe_v_q[1] & (pipe_id_q[1] == GNT_A);
  assign b_if.rvalid = pipe_v_q[1] & (pipe_id_q[1] == GNT_B);
  assign a_if.rdata  = bram_data_out;
  assign b_if.rdata  = bram_data_out;
endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - directed self-checking bench for bram_arbiter
module tb_bram_arbiter;
  localparam int NB    = 2;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          init_done;
  logic          bram_rd_en, bram_wr_en;
  logic [AW-1:0] bram_rd_addr, bram_wr_addr;
  logic [15:0]   bram_data_in;
  logic [15:0]   bram_data_out;
  logic [15:0]   mem [DEPTH];

  int n_checks = 0;
  int n_fails  = 0;

  bram_arbiter_if #(.ADDR_W(AW)) a_if ();
  bram_arbiter_if #(.ADDR_W(AW)) b_if ();

  bram_arbiter #(.NUM_BLOCKS(NB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .init_done    (init_done),
    .a_if         (a_if),
    .b_if         (b_if),
    .bram_rd_en   (bram_rd_en),
    .bram_wr_en   (bram_wr_en),
    .bram_rd_addr (bram_rd_addr),
    .bram_wr_addr (bram_wr_addr),
    .bram_data_in (bram_data_in),
    .bram_data_out(bram_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_wr_en) mem[bram_wr_addr] <= bram_data_in;
    if (bram_rd_en) bram_data_out <= mem[bram_rd_addr];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drop_reqs;
    a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = '0; a_if.wdata = '0;
    b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = '0; b_if.wdata = '0;
  endtask

  // Presents one request for one cycle and reports whether it was acked.
  task automatic op(input bit use_b, input bit we, input logic [AW-1:0] addr,
                    input logic [15:0] wd, output logic acked);
    if (use_b) begin
      b_if.req = 1'b1; b_if.we = we; b_if.addr = addr; b_if.wdata = wd;
    end else begin
      a_if.req = 1'b1; a_if.we = we; a_if.addr = addr; a_if.wdata = wd;
    end
    #1;
    acked = use_b ? b_if.ack : a_if.ack;
    step();
    drop_reqs();
  endtask

  // Steps through an initialisation pass, counting in-order zero writes.
  task automatic run_init(output int good, output int nwr, output int done_cyc);
    good = 0; nwr = 0; done_cyc = -1;
    for (int c = 1; c <= 600; c++) begin
      step();
      if (bram_wr_en) begin
        if (bram_wr_addr == AW'(nwr) && bram_data_in == 16'h0000) good++;
        nwr++;
      end
      if (init_done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int good, nwr, done_cyc;
    logic acked;
    rst_n = 1'b0; clear = 1'b0; drop_reqs();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({init_done, bram_wr_en, bram_rd_en, a_if.ack, b_if.ack, a_if.rvalid, b_if.rvalid} !== 7'b0) begin
      n_fails++;
      $display("FAIL reset_flags: got %b want 0000000",
               {init_done, bram_wr_en, bram_rd_en, a_if.ack, b_if.ack, a_if.rvalid, b_if.rvalid});
    end
    n_checks++;
    if ({bram_rd_addr, bram_wr_addr, bram_data_in} !== '0) begin
      n_fails++;
      $display("FAIL reset_regs: rd_addr=%h wr_addr=%h data_in=%h want 0", bram_rd_addr, bram_wr_addr, bram_data_in);
    end
    rst_n = 1'b1;
    run_init(good, nwr, done_cyc);
    n_checks++;
    if (good !== 512 || nwr !== 512) begin
      n_fails++;
      $display("FAIL init_writes: good=%0d total=%0d want 512/512", good, nwr);
    end
    n_checks++;
    if (done_cyc !== 512) begin
      n_fails++;
      $display("FAIL init_done_cycle: got %0d want 512", done_cyc);
    end
    op(1'b0, 1'b0, 9'h1FF, 16'h0, acked);
    n_checks++;
    if (acked !== 1'b1) begin
      n_fails++;
      $display("FAIL first_ack: got %b want 1", acked);
    end
    n_checks++;
    if (bram_wr_en !== 1'b0 || bram_rd_en !== 1'b1 || bram_rd_addr !== 9'h1FF) begin
      n_fails++;
      $display("FAIL post_init_issue: wr_en=%b rd_en=%b rd_addr=%h want 0/1/1ff", bram_wr_en, bram_rd_en, bram_rd_addr);
    end
    step();
    n_checks++;
    if (a_if.rvalid !== 1'b1 || a_if.rdata !== 16'h0000) begin
      n_fails++;
      $display("FAIL read_1ff: rvalid=%b rdata=%h want 1/0000", a_if.rvalid, a_if.rdata);
    end
  endtask

  task automatic test_write_read;
    logic ack_w, ack_r;
    op(1'b0, 1'b1, 9'h123, 16'hBEEF, ack_w);
    n_checks++;
    if (bram_wr_en !== 1'b1 || bram_wr_addr !== 9'h123 || bram_data_in !== 16'hBEEF) begin
      n_fails++;
      $display("FAIL write_issue: wr_en=%b addr=%h data=%h want 1/123/beef", bram_wr_en, bram_wr_addr, bram_data_in);
    end
    op(1'b0, 1'b0, 9'h123, 16'h0, ack_r);
    n_checks++;
    if (ack_w !== 1'b1 || ack_r !== 1'b1) begin
      n_fails++;
      $display("FAIL wr_rd_acks: got %b%b want 11", ack_w, ack_r);
    end
    n_checks++;
    if (bram_rd_en !== 1'b1 || bram_rd_addr !== 9'h123 || a_if.rvalid !== 1'b0) begin
      n_fails++;
      $display("FAIL read_issue: rd_en=%b addr=%h rvalid=%b want 1/123/0", bram_rd_en, bram_rd_addr, a_if.rvalid);
    end
    step();
    n_checks++;
    if (a_if.rvalid !== 1'b1 || a_if.rdata !== 16'hBEEF || b_if.rvalid !== 1'b0) begin
      n_fails++;
      $display("FAIL raw_read: a_rvalid=%b a_rdata=%h b_rvalid=%b want 1/beef/0", a_if.rvalid, a_if.rdata, b_if.rvalid);
    end
  endtask

  task automatic test_b_single_then_tie;
    logic acked;
    op(1'b1, 1'b0, 9'h123, 16'h0, acked);
    n_checks++;
    if (acked !== 1'b1) begin
      n_fails++;
      $display("FAIL b_single_ack: got %b want 1", acked);
    end
    a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 9'h1FF;
    b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 9'h123;
    #1;
    n_checks++;
    if ({a_if.ack, b_if.ack} !== 2'b10) begin
      n_fails++;
      $display("FAIL tie_first: acks=%b want 10", {a_if.ack, b_if.ack});
    end
    step();
    n_checks++;
    if ({a_if.ack, b_if.ack} !== 2'b01 || b_if.rvalid !== 1'b1 || b_if.rdata !== 16'hBEEF) begin
      n_fails++;
      $display("FAIL tie_second: acks=%b b_rvalid=%b b_rdata=%h want 01/1/beef",
               {a_if.ack, b_if.ack}, b_if.rvalid, b_if.rdata);
    end
    step();
    drop_reqs();
    n_checks++;
    if (a_if.rvalid !== 1'b1 || b_if.rvalid !== 1'b0 || a_if.rdata !== 16'h0000) begin
      n_fails++;
      $display("FAIL tie_resp_a: a_rvalid=%b b_rvalid=%b rdata=%h want 1/0/0000", a_if.rvalid, b_if.rvalid, a_if.rdata);
    end
    step();
    n_checks++;
    if (b_if.rvalid !== 1'b1 || a_if.rvalid !== 1'b0 || b_if.rdata !== 16'hBEEF) begin
      n_fails++;
      $display("FAIL tie_resp_b: b_rvalid=%b a_rvalid=%b rdata=%h want 1/0/beef", b_if.rvalid, a_if.rvalid, b_if.rdata);
    end
  endtask

  task automatic test_back_to_back;
    logic acked;
    logic [1:0] want;
    op(1'b0, 1'b1, 9'h010, 16'hAAAA, acked);
    op(1'b1, 1'b1, 9'h020, 16'hBBBB, acked);
    a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 9'h010;
    b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 9'h020;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) drop_reqs();
      #1;
      if (i < 6) begin
        want = (i % 2 == 0) ? 2'b10 : 2'b01;
        n_checks++;
        if ({a_if.ack, b_if.ack} !== want) begin
          n_fails++;
          $display("FAIL alt_ack[%0d]: got %b want %b", i, {a_if.ack, b_if.ack}, want);
        end
      end
      if (i >= 2) begin
        want = (i % 2 == 0) ? 2'b10 : 2'b01;
        n_checks++;
        if ({a_if.rvalid, b_if.rvalid} !== want ||
            bram_data_out !== ((i % 2 == 0) ? 16'hAAAA : 16'hBBBB)) begin
          n_fails++;
          $display("FAIL alt_resp[%0d]: rvalid=%b data=%h want %b/%h", i, {a_if.rvalid, b_if.rvalid},
                   bram_data_out, want, (i % 2 == 0) ? 16'hAAAA : 16'hBBBB);
        end
      end
      step();
    end
  endtask

  task automatic test_clear;
    logic acked;
    int good, nwr, done_cyc;
    op(1'b1, 1'b0, 9'h123, 16'h0, acked);
    clear = 1'b1;
    a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 9'h123;
    #1;
    n_checks++;
    if (acked !== 1'b1 || a_if.ack !== 1'b0 || bram_rd_en !== 1'b1) begin
      n_fails++;
      $display("FAIL clear_cycle: b_ack=%b a_ack=%b rd_en=%b want 1/0/1", acked, a_if.ack, bram_rd_en);
    end
    step();
    clear = 1'b0;
    #1;
    n_checks++;
    if (b_if.rvalid !== 1'b1 || b_if.rdata !== 16'hBEEF || init_done !== 1'b0 || a_if.ack !== 1'b0) begin
      n_fails++;
      $display("FAIL clear_drain: b_rvalid=%b rdata=%h init_done=%b a_ack=%b want 1/beef/0/0",
               b_if.rvalid, b_if.rdata, init_done, a_if.ack);
    end
    drop_reqs();
    run_init(good, nwr, done_cyc);
    n_checks++;
    if (good !== 512 || nwr !== 512 || done_cyc !== 512) begin
      n_fails++;
      $display("FAIL clear_reinit: good=%0d total=%0d done=%0d want 512/512/512", good, nwr, done_cyc);
    end
    op(1'b0, 1'b0, 9'h123, 16'h0, acked);
    step();
    n_checks++;
    if (acked !== 1'b1 || a_if.rvalid !== 1'b1 || a_if.rdata !== 16'h0000) begin
      n_fails++;
      $display("FAIL clear_zeroed: ack=%b rvalid=%b rdata=%h want 1/1/0000", acked, a_if.rvalid, a_if.rdata);
    end
  endtask

  task automatic test_reset_mid_init;
    int good, nwr, done_cyc;
    bit hit;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (bram_wr_en && bram_wr_addr == 9'd100) begin
        hit = 1'b1;
        break;
      end
    end
    n_checks++;
    if (hit !== 1'b1) begin
      n_fails++;
      $display("FAIL reach_addr100: got %b want 1", hit);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({init_done, bram_wr_en, bram_rd_en, a_if.rvalid, b_if.rvalid} !== 5'b0 ||
        bram_wr_addr !== '0 || bram_data_in !== '0) begin
      n_fails++;
      $display("FAIL async_reset: flags=%b wr_addr=%h data=%h want 0/0/0",
               {init_done, bram_wr_en, bram_rd_en, a_if.rvalid, b_if.rvalid}, bram_wr_addr, bram_data_in);
    end
    step();
    rst_n = 1'b1;
    run_init(good, nwr, done_cyc);
    n_checks++;
    if (good !== 512 || nwr !== 512 || done_cyc !== 512) begin
      n_fails++;
      $display("FAIL restart_init: good=%0d total=%0d done=%0d want 512/512/512", good, nwr, done_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_b_single_then_tie();
    test_back_to_back();
    test_clear();
    test_reset_mid_init();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-port round-robin arbiter and initialiser for the banked `bram` block, which holds NUM_BLOCKS × 256 words of 16 bits. After reset it zero-fills the whole array. It then grants at most one read or write per cycle to one of two requesters, A (host/config side) and B (fabric side), and returns each read result only to the requester that issued it. It sits directly in front of `bram` and is the only driver of the `bram` ports.

## Interface
- NUM_BLOCKS, 16, number of 256×16 blocks; passed through to `bram`.
- ADDR_W (localparam), 8+$clog2(NUM_BLOCKS), word address width.
- DEPTH (localparam), NUM_BLOCKS*256, total words.

- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  one-cycle pulse that requests a re-zero of the array; ignored while init_done=0.
- init_done  out  1  high when the array is initialised and requests can be accepted.
- a_req / b_req  in  1  request valid; held with its fields until the matching ack.
- a_we / b_we  in  1  1 = write, 0 = read.
- a_addr / b_addr  in  ADDR_W  word address.
- a_wdata / b_wdata  in  16  write data.
- a_ack / b_ack  out  1  combinational; request accepted this cycle.
- a_rvalid / b_rvalid  out  1  read data valid for that requester.
- a_rdata / b_rdata  out  16  read data; equal to bram_data_out and meaningful only while the matching rvalid is high.
- bram_rd_en, bram_wr_en  out  1  registered enables to `bram`.
- bram_rd_addr, bram_wr_addr  out  ADDR_W  registered addresses.
- bram_data_in  out  16  registered write data.
- bram_data_out  in  16  `bram` read port; valid one cycle after bram_rd_en.

## Operation
- FSM with two states, INIT and RUN. Reset enters INIT with the counter at 0.
- INIT:
  - Each cycle, register bram_wr_en=1, bram_wr_addr=counter, bram_data_in=0.
  - The counter increments, and wraps DEPTH-1 → 0 on the final write.
  - On the edge that issues address DEPTH-1, the FSM moves to RUN and init_done becomes 1.
  - No acks are given in INIT.
- RUN, per cycle:
  - Only A requesting: grant A. Only B requesting: grant B.
  - Both requesting: grant the requester opposite last_grant.
  - ack_x = req_x & grant_x & (state==RUN) & !clear.
  - last_grant updates only on an accepted request. Its reset value is B, so A wins the first tie.
- On the edge where ack_x=1:
  - Write (we=1): register bram_wr_en=1 with the requester's addr and wdata.
  - Read (we=0): register bram_rd_en=1 with the requester's addr, and push the requester ID into a 2-stage valid/ID pipe.
- With no accept, bram_rd_en and bram_wr_en deassert the next cycle. Address and data registers hold their last value.
- clear=1 in RUN:
  - No ack that cycle.
  - Next state is INIT with the counter at 0, and init_done drops on that edge.
  - Reads already in the pipe still complete and raise rvalid.
- At most one `bram` operation is issued per cycle, so read-during-write collisions cannot occur.
- Reset values: init_done=0, all ack=0, all rvalid=0, bram_rd_en=0, bram_wr_en=0, addresses=0, bram_data_in=0, counter=0, last_grant=B, pipe empty. Asserting rst_n=0 mid-INIT or mid-read discards everything, and initialisation restarts from address 0.

## Timing
- Initialisation lasts DEPTH cycles of bram_wr_en. The first ack is possible in the cycle after the last write is issued, which is cycle DEPTH after reset release.
- Write: accept in cycle N; bram_wr_en high in N+1; the word is stored at the end of N+1.
- Read: accept in cycle N; bram_rd_en high in N+1; rvalid_x and rdata_x valid in N+2. Latency is 2 cycles and is fixed.
- A read accepted in N+1 to the address written by an op accepted in N returns the new data.
- Throughput is 1 op/cycle sustained. Under continuous contention, grants alternate A, B, A, B.
- Read responses return in acceptance order with no reordering. a_rvalid and b_rvalid are never high together.

## Test plan
- Reset, NUM_BLOCKS=2 → bram_wr_en high for exactly 512 consecutive cycles over addresses 0..511 with data 0; init_done rises at cycle 512; a subsequent read of 0x1FF returns 0x0000.
- A writes 0xBEEF to 0x123 in cycle N, A reads 0x123 in N+1 → a_rvalid in N+3 with a_rdata=0xBEEF; b_rvalid stays 0.
- A and B both hold reads for 6 cycles → acks alternate A,B,A,B,A,B; the rvalid pattern follows 2 cycles later with each requester's correct data.
- B issues a single read while A is idle → b_ack in the same cycle as b_req; when A and B then tie, A is granted because last_grant=B.
- clear pulsed 1 cycle after a B read is accepted → b_rvalid still fires 2 cycles after the accept; then DEPTH zero-writes occur and the earlier 0xBEEF at 0x123 reads back as 0.
- rst_n asserted mid-INIT at address 100 → all outputs drop to reset values immediately; after release, init restarts at address 0 and takes the full DEPTH cycles.
